// File: rtl/mux_operand_stage.sv
// mux_operand_stage: N_IN-way operand selector feeding a valid/ready stage.
// A main output register and one skid entry let the stage take one operand
// per cycle and still absorb a single-cycle stall from the ALU side. in_ready
// comes from a flop, so out_ready never reaches in_ready combinationally.
module mux_operand_stage #(
    parameter int DATA_W = 32,
    parameter int N_IN   = 4,
    parameter int SEL_W  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [SEL_W-1:0]         seletor,
    input  logic [N_IN*DATA_W-1:0]   in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     hold,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sel_err,
    output logic                     err_sticky
);

    // Occupancy of the main register plus the skid entry.
    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [DATA_W-1:0]   r_main_data;
    logic [DATA_W-1:0]   r_skid_data;
    logic                r_in_ready;
    logic                r_sel_err;
    logic                r_err_sticky;
    logic [DATA_W-1:0]   w_sel_data;
    logic                w_sel_bad;
    logic                w_accept;
    logic                w_pop;

    // Source select; codes at or above N_IN produce all zeros.
    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (seletor == SEL_W'(k))
                w_sel_data = in_data[k*DATA_W +: DATA_W];
        end
    end

    // Widened by one bit so the compare is well formed when 2^SEL_W == N_IN.
    assign w_sel_bad = ({1'b0, seletor} >= (SEL_W+1)'(N_IN));
    assign w_accept  = in_valid & r_in_ready;
    assign w_pop     = out_valid & out_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_EMPTY;
        else        r_state <= w_state_next;
    end

    // Next occupancy from accept/pop; FULL never accepts since in_ready is low.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_EMPTY: if (w_accept) w_state_next = S_ONE;
            S_ONE: begin
                if (w_accept && !w_pop)      w_state_next = S_FULL;
                else if (!w_accept && w_pop) w_state_next = S_EMPTY;
            end
            S_FULL:  if (w_pop) w_state_next = S_ONE;
            default: w_state_next = S_EMPTY;
        endcase
    end

    // Outputs are all straight from flops.
    always_comb begin
        out_valid  = (r_state != S_EMPTY);
        out_data   = r_main_data;
        in_ready   = r_in_ready;
        sel_err    = r_sel_err;
        err_sticky = r_err_sticky;
    end

    // Ready for the next cycle: skid will be free and no stall requested.
    always_ff @(posedge clk) begin
        if (!reset) r_in_ready <= 1'b1;
        else        r_in_ready <= (w_state_next != S_FULL) & ~hold;
    end

    // Datapath: load main, park in skid, or promote skid to main.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_main_data <= '0;
            r_skid_data <= '0;
        end else begin
            case (r_state)
                S_EMPTY: if (w_accept) r_main_data <= w_sel_data;
                S_ONE: begin
                    if (w_accept && w_pop)       r_main_data <= w_sel_data;
                    else if (w_accept && !w_pop) r_skid_data <= w_sel_data;
                end
                S_FULL:  if (w_pop) r_main_data <= r_skid_data;
                default: ;
            endcase
        end
    end

    // Selector error pulse and its sticky copy, both on the accepting edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sel_err    <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            r_sel_err    <= w_accept & w_sel_bad;
            r_err_sticky <= r_err_sticky | (w_accept & w_sel_bad);
        end
    end

endmodule

// File: tb/tb_mux_operand_stage.sv
// Bench for mux_operand_stage: a 4-input instance with a scoreboard on the
// output handshake, plus a 3-input instance for out-of-range selectors.
module tb_mux_operand_stage;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    seletor;
    logic [127:0]  in_data;
    logic          in_valid, in_ready, hold;
    logic [31:0]   out_data;
    logic          out_valid, out_ready, sel_err, err_sticky;

    logic [1:0]    sel3;
    logic [95:0]   data3;
    logic          valid3, ready3, hold3;
    logic [31:0]   out_data3;
    logic          out_valid3, out_ready3, sel_err3, sticky3;

    int n_vec = 0, n_miss = 0;
    int sb_vec = 0, sb_miss = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    mux_operand_stage #(.DATA_W(32), .N_IN(4), .SEL_W(2)) dut (
        .clk(clk), .reset(reset), .seletor(seletor), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .hold(hold),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .sel_err(sel_err), .err_sticky(err_sticky));

    mux_operand_stage #(.DATA_W(32), .N_IN(3), .SEL_W(2)) dut3 (
        .clk(clk), .reset(reset), .seletor(sel3), .in_data(data3),
        .in_valid(valid3), .in_ready(ready3), .hold(hold3),
        .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
        .sel_err(sel_err3), .err_sticky(sticky3));

    function automatic logic [31:0] model(input logic [127:0] d, input logic [1:0] s);
        return d[s*32 +: 32];
    endfunction

    // Scoreboard: push on accept, pop and compare on output transfer.
    always @(negedge clk) begin
        if (!reset) sb.delete();
        else begin
            if (in_valid && in_ready) sb.push_back(model(in_data, seletor));
            if (out_valid && out_ready) begin
                sb_vec++;
                if (sb.size() == 0) begin
                    sb_miss++;
                    $display("FAIL sb_unexpected: got %h, required nothing", out_data);
                end else begin
                    logic [31:0] e;
                    e = sb.pop_front();
                    if (out_data !== e) begin
                        sb_miss++;
                        $display("FAIL sb_data: got %h, required %h", out_data, e);
                    end
                end
            end
        end
    end

    // Hold in_valid until accepted; returns at accept edge + 1.
    task automatic offer(input logic [1:0] s, output int stalls);
        seletor = s;
        in_valid = 1'b1;
        stalls = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            stalls++;
            if (stalls > 50) begin
                n_vec++; n_miss++;
                $display("FAIL offer_timeout: in_ready stuck at %b, required 1", in_ready);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        repeat (6) @(posedge clk);
        #1;
        n_vec++;
        if (sb.size() !== 0) begin
            n_miss++;
            $display("FAIL drain: %0d words outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; seletor = '0; in_data = '0; in_valid = 0; hold = 0; out_ready = 0;
        sel3 = '0; data3 = '0; valid3 = 0; hold3 = 0; out_ready3 = 0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({out_valid, out_data, sel_err, err_sticky} !== 35'd0) begin
            n_miss++;
            $display("FAIL reset_state: got v=%b d=%h e=%b s=%b, required all 0",
                     out_valid, out_data, sel_err, err_sticky);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_miss++;
            $display("FAIL reset_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_mux_sweep();
        logic [31:0] exp_tab [4];
        int st;
        exp_tab = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        in_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(2'(i), st);
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== exp_tab[i]) begin
                n_miss++;
                $display("FAIL sweep_%0d: got v=%b d=%h, required v=1 d=%h",
                         i, out_valid, out_data, exp_tab[i]);
            end
        end
        in_valid = 1'b0;
        wait_drain();
    endtask

    task automatic test_back_pressure();
        int st;
        out_ready = 1'b0;
        in_data = '0;
        in_data[31:0] = 32'hA; offer(2'd0, st);
        in_data[31:0] = 32'hB; offer(2'd0, st);
        in_data[31:0] = 32'hC;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'hA) begin
                n_miss++;
                $display("FAIL bp_hold: got rdy=%b v=%b d=%h, required rdy=0 v=1 d=a",
                         in_ready, out_valid, out_data);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        offer(2'd0, st);
        in_valid = 1'b0;
        n_vec++;
        if (st < 1) begin
            n_miss++;
            $display("FAIL bp_c_stall: got %0d stall cycles, required >=1", st);
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int st;
        int stalls = 0;
        out_ready = 1'b1;
        in_data = '0;
        for (int i = 0; i < 16; i++) begin
            in_data[31:0] = 32'(i);
            offer(2'd0, st);
            stalls += st;
        end
        in_valid = 1'b0;
        n_vec++;
        if (stalls != 0) begin
            n_miss++;
            $display("FAIL stream_stalls: got %0d, required 0", stalls);
        end
        wait_drain();
    endtask

    task automatic test_hold();
        int st;
        out_ready = 1'b0;
        in_data = '0;
        in_data[31:0] = 32'h5; offer(2'd0, st);
        in_data[31:0] = 32'h6; offer(2'd0, st);
        in_data[31:0] = 32'h7;
        hold = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++;
            if (in_ready !== 1'b0) begin
                n_miss++;
                $display("FAIL hold_ready_%0d: got %b, required 0", i, in_ready);
            end
        end
        n_vec++;
        if (sb.size() !== 0) begin
            n_miss++;
            $display("FAIL hold_drain: %0d words left, required 0", sb.size());
        end
        @(posedge clk); #1;
        hold = 1'b0;
        offer(2'd0, st);
        in_valid = 1'b0;
        n_vec++;
        if (st !== 1) begin
            n_miss++;
            $display("FAIL hold_resume: got %0d stall cycles, required 1", st);
        end
        wait_drain();
    endtask

    task automatic test_illegal_sel();
        data3 = {32'h33333333, 32'h22222222, 32'h11111111};
        out_ready3 = 1'b1;
        sel3 = 2'd3;
        valid3 = 1'b1;
        @(posedge clk); #1;
        valid3 = 1'b0;
        n_vec++;
        if (out_valid3 !== 1'b1 || out_data3 !== 32'h0 || sel_err3 !== 1'b1 || sticky3 !== 1'b1) begin
            n_miss++;
            $display("FAIL illegal_out: got v=%b d=%h e=%b s=%b, required v=1 d=0 e=1 s=1",
                     out_valid3, out_data3, sel_err3, sticky3);
        end
        @(posedge clk); #1;
        n_vec++;
        if (sel_err3 !== 1'b0 || sticky3 !== 1'b1) begin
            n_miss++;
            $display("FAIL illegal_pulse: got e=%b s=%b, required e=0 s=1", sel_err3, sticky3);
        end
        sel3 = 2'd2;
        valid3 = 1'b1;
        @(posedge clk); #1;
        valid3 = 1'b0;
        n_vec++;
        if (out_data3 !== 32'h33333333 || sel_err3 !== 1'b0 || sticky3 !== 1'b1) begin
            n_miss++;
            $display("FAIL legal_after_err: got d=%h e=%b s=%b, required d=33333333 e=0 s=1",
                     out_data3, sel_err3, sticky3);
        end
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (sticky3 !== 1'b1) begin
            n_miss++;
            $display("FAIL sticky_keep: got %b, required 1", sticky3);
        end
    endtask

    task automatic test_reset_mid();
        int st;
        out_ready = 1'b0;
        in_data = '0;
        in_data[31:0] = 32'hD1; offer(2'd0, st);
        in_data[31:0] = 32'hD2; offer(2'd0, st);
        in_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || err_sticky !== 1'b0 || sticky3 !== 1'b0) begin
            n_miss++;
            $display("FAIL mid_reset: got v=%b d=%h s=%b s3=%b, required 0 0 0 0",
                     out_valid, out_data, err_sticky, sticky3);
        end
        @(posedge clk); #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_miss++;
            $display("FAIL mid_reset_ready: got %b, required 1", in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_miss++;
                $display("FAIL mid_reset_stale: got v=%b d=%h, required v=0", out_valid, out_data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mux_sweep();
        test_back_pressure();
        test_back_to_back();
        test_hold();
        test_illegal_sel();
        test_reset_mid();
        @(posedge clk); #1;
        n_vec  += sb_vec;
        n_miss += sb_miss;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mux_operand_stage.md
Name: mux_operand_stage

Overview:
- Parametrised, registered successor to the 2:1 ALU-operand selector.
- Selects one of N_IN operand sources (read_data2, memory_data, immediates, PC, …) per transfer and delivers it through a valid/ready pipeline stage with a 2-entry skid buffer.
- Sits between register-file/memory outputs and the ALU operand port; sustains one operand per cycle under back-pressure.
- Flags out-of-range selector codes.

Parameters:
- DATA_W, 32, width of each source and of the output.
- N_IN, 4, number of selectable sources (2..16).
- SEL_W, 2, selector width; must satisfy 2^SEL_W >= N_IN.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- seletor  input  SEL_W  source index, sampled with in_valid.
- in_data  input  N_IN*DATA_W  flattened sources; source k = in_data[k*DATA_W +: DATA_W].
- in_valid  input  1  upstream offers a transfer.
- in_ready  output  1  stage can accept.
- hold  input  1  freeze acceptance (control-unit stall).
- out_data  output  DATA_W  selected operand.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts.
- sel_err  output  1  one-cycle pulse: an accepted transfer had seletor >= N_IN.
- err_sticky  output  1  set by any sel_err; cleared only by reset.

Behaviour:
- Reset (reset==0 at a rising edge):
  - out_valid=0, out_data=0, sel_err=0, err_sticky=0.
  - skid entry invalid and zeroed.
  - in_ready=1 the cycle after reset deasserts.
  - Reset mid-operation discards both entries; no partial output.
- Accept: in_valid & in_ready at an edge.
  - Selected word = source[seletor] if seletor < N_IN, else all zeros.
  - seletor and data are captured together; later changes have no effect.
- Latency: data accepted at edge t appears on out_data/out_valid after edge t (one cycle) when the main register is free.
- Output transfer: out_valid & out_ready at an edge.
  - out_data and out_valid are held stable while out_valid=1 & out_ready=0.
- in_ready = ~skid_valid & ~hold, registered (no combinational path from out_ready).
- hold blocks acceptance only; buffered data still drains to the output.
- States, by buffer occupancy:
  - EMPTY (0 entries):
    - accept -> ONE.
  - ONE (main valid):
    - accept & pop -> ONE; main reloads with the new word, giving 1 word/cycle throughput.
    - accept & no pop -> FULL; the new word goes to skid.
    - pop & no accept -> EMPTY.
  - FULL (main + skid valid; in_ready=0):
    - pop -> ONE; skid moves to main in the same edge.
    - no pop -> stay FULL.
- Ordering is strictly FIFO; no word is dropped or duplicated.
- sel_err is asserted the cycle after the accepting edge, for exactly one cycle per offending transfer. err_sticky sets on that same edge.
- Only selector bits [SEL_W-1:0] are used; no arithmetic is performed on the data.

Test Plan:
- Mux sweep:
  - Stimulus: N_IN=4; sources 0x11111111, 0x22222222, 0x33333333, 0x44444444; out_ready=1; seletor 0,1,2,3 on consecutive cycles.
  - Response: out_data 0x11111111..0x44444444 on cycles 1..4; out_valid continuously 1.
- Back-pressure:
  - Stimulus: out_ready=0; offer A=0xA, B=0xB, C=0xC.
  - Response: A and B accepted; in_ready=0 after B; C held off; out_data stays 0xA.
  - Then out_ready=1: outputs 0xA, 0xB, 0xC in order, no loss.
- Simultaneous push/pop in ONE:
  - Stimulus: continuous stream 0..15, out_ready=1.
  - Response: one output per cycle; in_ready never drops.
- Illegal selector:
  - Stimulus: N_IN=3, seletor=3, data offered.
  - Response: out_data=0; sel_err pulses one cycle; err_sticky=1 and stays 1 until reset.
- Hold:
  - Stimulus: FULL with 0x5/0x6; hold=1, out_ready=1.
  - Response: 0x5 then 0x6 drain; in_ready=0 throughout hold; accepts resume the cycle after hold=0.
- Reset mid-operation:
  - Stimulus: FULL, then reset=0 for one edge.
  - Response: out_valid=0, out_data=0, err_sticky=0; in_ready=1 next cycle; old data never appears.
